// File: rtl/alu_result_display.sv
// Display side of the 4-bit ALU. It turns the 5-bit result into BCD with a sequential
// double-dabble engine, then scans ones/tens/mode/blank onto a common-anode 7-segment display.
module alu_result_display #(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] result,
    input  logic [1:0] mode,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       dp_n,
    output logic       busy
);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t     state_reg;
    logic [4:0] last_val_reg;
    logic [4:0] snap_reg;
    logic       snap_msb_reg;
    logic [7:0] bcd_reg;
    logic [2:0] shift_cnt_reg;
    logic       busy_reg;
    logic [3:0] disp_tens_reg;
    logic [3:0] disp_ones_reg;
    logic       disp_carry_reg;
    logic [1:0] disp_mode_reg;

    logic [CNT_W-1:0] refresh_cnt_reg;
    logic [1:0]       slot_reg;
    logic [6:0]       seg_reg, seg_next;
    logic [3:0]       an_reg, an_next;
    logic             dp_reg, dp_next;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    // Add-3 correction applied to each BCD nibble before every shift.
    logic [7:0] bcd_adj;
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                    bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_val_reg   <= '0;
            snap_reg       <= '0;
            snap_msb_reg   <= 1'b0;
            bcd_reg        <= '0;
            shift_cnt_reg  <= '0;
            busy_reg       <= 1'b0;
            disp_tens_reg  <= '0;
            disp_ones_reg  <= '0;
            disp_carry_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (result != last_val_reg) begin
                        snap_reg      <= result;
                        last_val_reg  <= result;
                        snap_msb_reg  <= result[4];
                        bcd_reg       <= '0;
                        shift_cnt_reg <= 3'd5;
                        busy_reg      <= 1'b1;
                        state_reg     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_reg       <= {bcd_adj[6:0], snap_reg[4]};
                    snap_reg      <= {snap_reg[3:0], 1'b0};
                    shift_cnt_reg <= shift_cnt_reg - 3'd1;
                    if (shift_cnt_reg == 3'd1)
                        state_reg <= COMMIT;
                end
                COMMIT: begin
                    disp_tens_reg  <= bcd_reg[7:4];
                    disp_ones_reg  <= bcd_reg[3:0];
                    disp_carry_reg <= snap_msb_reg;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        seg_next = 7'h7F;
        an_next  = 4'hF;
        dp_next  = 1'b1;
        case (slot_reg)
            2'd0: begin
                an_next  = 4'b1110;
                seg_next = seg_of(disp_ones_reg);
                dp_next  = ~disp_carry_reg;
            end
            2'd1: begin
                if (!(BLANK_LEADING && disp_tens_reg == 4'd0)) begin
                    an_next  = 4'b1101;
                    seg_next = seg_of(disp_tens_reg);
                end
            end
            2'd2: begin
                an_next  = 4'b1011;
                seg_next = seg_of({2'b00, disp_mode_reg});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt_reg <= '0;
            slot_reg        <= '0;
            disp_mode_reg   <= '0;
            seg_reg         <= 7'h7F;
            an_reg          <= 4'hF;
            dp_reg          <= 1'b1;
        end else begin
            disp_mode_reg <= mode;
            if (refresh_cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt_reg <= '0;
                slot_reg        <= slot_reg + 2'd1;
            end else begin
                refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
            end
            seg_reg <= seg_next;
            an_reg  <= an_next;
            dp_reg  <= dp_next;
        end
    end

    assign seg_n = seg_reg;
    assign an_n  = an_reg;
    assign dp_n  = dp_reg;
    assign busy  = busy_reg;
endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with a fast refresh divider; one line per transaction.
module tb_alu_result_display;
    logic       clk;
    logic       rst_n;
    logic [4:0] result;
    logic [1:0] mode;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       dp_n;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [3:0] an_seq [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};

    alu_result_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .result(result), .mode(mode),
        .seg_n(seg_n), .an_n(an_n), .dp_n(dp_n), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Align to the first cycle of slot 0 on the outputs, then sample slots 0..2.
    task automatic check_frame(input string tag, input int val, input int md);
        int n;
        int tens;
        int ones;
        logic [6:0] s0, s1, s2;
        logic [3:0] a0, a1, a2;
        logic d0, d1, d2;
        tens = val / 10;
        ones = val % 10;
        n = 0;
        while (an_n == 4'b1110 && n < 64) begin @(negedge clk); n++; end
        while (an_n != 4'b1110 && n < 64) begin @(negedge clk); n++; end
        check({tag, " sync"}, {31'd0, n < 64}, 32'd1);
        a0 = an_n; s0 = seg_n; d0 = dp_n;
        repeat (4) @(negedge clk);
        a1 = an_n; s1 = seg_n; d1 = dp_n;
        repeat (4) @(negedge clk);
        a2 = an_n; s2 = seg_n; d2 = dp_n;
        check({tag, " an0"}, {28'd0, a0}, 32'hE);
        check({tag, " ones"}, {25'd0, s0}, {25'd0, seg_tab[ones]});
        check({tag, " dp0"}, {31'd0, d0}, (val >= 16) ? 32'd0 : 32'd1);
        if (tens == 0) begin
            check({tag, " an1 blank"}, {28'd0, a1}, 32'hF);
            check({tag, " seg1 blank"}, {25'd0, s1}, 32'h7F);
        end else begin
            check({tag, " an1"}, {28'd0, a1}, 32'hD);
            check({tag, " tens"}, {25'd0, s1}, {25'd0, seg_tab[tens]});
        end
        check({tag, " dp1"}, {31'd0, d1}, 32'd1);
        check({tag, " an2"}, {28'd0, a2}, 32'hB);
        check({tag, " mode"}, {25'd0, s2}, {25'd0, seg_tab[md]});
        check({tag, " dp2"}, {31'd0, d2}, 32'd1);
        $display("frame %s: value=%0d mode=%0d seg0=%b seg1=%b seg2=%b dp0=%b",
                 tag, val, md, s0, s1, s2, d0);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max) begin @(negedge clk); n++; end
        check({tag, " busy drop"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        result = 5'd0;
        mode   = 2'd0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst seg", {25'd0, seg_n}, 32'h7F);
        check("rst an", {28'd0, an_n}, 32'hF);
        check("rst dp", {31'd0, dp_n}, 32'd1);
        check("rst busy", {31'd0, busy}, 32'd0);
        $display("reset: seg=%b an=%b dp=%b busy=%b", seg_n, an_n, dp_n, busy);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle busy", {31'd0, busy}, 32'd0);
        end
        check_frame("idle", 0, 0);

        // Basic conversion 0 -> 23, busy window E0..E5
        result = 5'd23;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("conv busy E%0d", i), {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check("conv busy E6", {31'd0, busy}, 32'd0);
        $display("conv: result=23 busy=%b", busy);
        check_frame("conv23", 23, 0);

        // Sweep all results with cycling mode
        for (int i = 0; i < 32; i++) begin
            result = 5'(i);
            mode   = 2'(i % 4);
            repeat (10) @(negedge clk);
            check_frame($sformatf("sweep%0d", i), i, i % 4);
        end

        // Changes while busy: 7 commits, 12 is skipped, 19 follows
        mode   = 2'd1;
        result = 5'd7;
        @(negedge clk);
        @(negedge clk);
        result = 5'd12;
        @(negedge clk);
        result = 5'd19;
        repeat (4) @(negedge clk);
        check("busy7 busy", {31'd0, busy}, 32'd0);
        check("busy7 tens", {28'd0, dut.disp_tens_reg}, 32'd0);
        check("busy7 ones", {28'd0, dut.disp_ones_reg}, 32'd7);
        $display("busy-change: committed tens=%0d ones=%0d", dut.disp_tens_reg, dut.disp_ones_reg);
        @(negedge clk);
        check("busy19 restart", {31'd0, busy}, 32'd1);
        wait_idle("busy19", 10);
        check("busy19 tens", {28'd0, dut.disp_tens_reg}, 32'd1);
        check("busy19 ones", {28'd0, dut.disp_ones_reg}, 32'd9);
        check_frame("busy19", 19, 1);

        // Scan timing with tens nonzero
        begin
            int n;
            n = 0;
            while (an_n == 4'b1110 && n < 64) begin @(negedge clk); n++; end
            while (an_n != 4'b1110 && n < 64) begin @(negedge clk); n++; end
            check("scan sync", {31'd0, n < 64}, 32'd1);
            for (int k = 0; k < 32; k++) begin
                check($sformatf("scan an k%0d", k), {28'd0, an_n}, {28'd0, an_seq[(k / 4) % 4]});
                check($sformatf("scan onehot k%0d", k), {31'd0, $countones(~an_n) <= 1}, 32'd1);
                @(negedge clk);
            end
            $display("scan: 32 cycles of an_n checked");
        end

        // Reset in the middle of a conversion
        result = 5'd31;
        repeat (10) @(negedge clk);
        check("pre-abort ones", {28'd0, dut.disp_ones_reg}, 32'd1);
        result = 5'd5;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort tens", {28'd0, dut.disp_tens_reg}, 32'd0);
        check("abort ones", {28'd0, dut.disp_ones_reg}, 32'd0);
        check("abort carry", {31'd0, dut.disp_carry_reg}, 32'd0);
        check("abort seg", {25'd0, seg_n}, 32'h7F);
        check("abort an", {28'd0, an_n}, 32'hF);
        check("abort dp", {31'd0, dp_n}, 32'd1);
        $display("abort: busy=%b seg=%b an=%b", busy, seg_n, an_n);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart busy", {31'd0, busy}, 32'd1);
        wait_idle("restart", 7);
        check("restart ones", {28'd0, dut.disp_ones_reg}, 32'd5);
        check("restart tens", {28'd0, dut.disp_tens_reg}, 32'd0);
        check_frame("restart5", 5, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
